// File: rtl/rc4_prga_engine.sv
`default_nettype none
// ============================================================================
// Module   : rc4_prga_engine
// Brief    : RC4 PRGA decrypt engine; XORs keystream with E ROM into D RAM.
// Revision : 1.0 - initial release
// ============================================================================
module rc4_prga_engine #(
    parameter int S_AW       = 8,
    parameter int E_AW       = 5,
    parameter int RD_LAT     = 1,
    parameter int CHECK_MODE = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [E_AW:0]   msg_len,
    output logic [S_AW-1:0] s_address,
    output logic [S_AW-1:0] s_data,
    output logic            s_wren,
    input  logic [S_AW-1:0] s_ram_q,
    output logic [E_AW-1:0] e_address,
    input  logic [7:0]      e_rom_q,
    output logic [E_AW-1:0] d_address,
    output logic [7:0]      d_data,
    output logic            d_wren,
    output logic            valid,
    output logic [E_AW-1:0] fail_addr,
    output logic            finish
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_SI   = 4'd1,
        ST_WAIT_SI = 4'd2,
        ST_GET_SI  = 4'd3,
        ST_RD_SJ   = 4'd4,
        ST_WAIT_SJ = 4'd5,
        ST_GET_SJ  = 4'd6,
        ST_WR_SI   = 4'd7,
        ST_WR_SJ   = 4'd8,
        ST_RD_F    = 4'd9,
        ST_WAIT_F  = 4'd10,
        ST_GET_F   = 4'd11,
        ST_WR_D    = 4'd12,
        ST_DONE    = 4'd13
    } state_t;

    localparam bit         c_use_wait  = (RD_LAT > 1);
    localparam logic [3:0] c_wait_init = 4'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    state_t          r_state;
    logic [3:0]      r_wait;
    logic [S_AW-1:0] r_i;
    logic [S_AW-1:0] r_j;
    logic [S_AW-1:0] r_si;
    logic [S_AW-1:0] r_sj;
    logic [E_AW-1:0] r_k;
    logic [E_AW:0]   r_len;

    logic [7:0]      w_f8;
    logic            w_bad;
    logic            w_last;

    // Keystream byte is the low 8 bits of the S entry (zero-extended for narrow S).
    generate
        if (S_AW >= 8) begin : g_f_trunc
            assign w_f8 = s_ram_q[7:0];
        end else begin : g_f_ext
            assign w_f8 = {{(8 - S_AW){1'b0}}, s_ram_q};
        end
    endgenerate

    function automatic logic byte_ok(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    // d_data still holds the byte just written while in WR_D.
    assign w_bad  = (CHECK_MODE == 1) && !byte_ok(d_data);
    assign w_last = ({1'b0, r_k} == (r_len - (E_AW + 1)'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_wait    <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_si      <= '0;
            r_sj      <= '0;
            r_k       <= '0;
            r_len     <= '0;
            s_address <= '0;
            s_data    <= '0;
            s_wren    <= 1'b0;
            e_address <= '0;
            d_address <= '0;
            d_data    <= '0;
            d_wren    <= 1'b0;
            valid     <= 1'b0;
            fail_addr <= '0;
            finish    <= 1'b0;
        end else begin
            s_wren <= 1'b0;
            d_wren <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len     <= msg_len;
                        r_i       <= S_AW'(1);
                        r_j       <= '0;
                        r_k       <= '0;
                        valid     <= 1'b0;
                        fail_addr <= '0;
                        if (msg_len == '0) begin
                            valid   <= 1'b1;
                            finish  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            s_address <= S_AW'(1);
                            r_state   <= ST_RD_SI;
                        end
                    end
                end
                ST_RD_SI: begin
                    if (c_use_wait) begin
                        r_wait  <= c_wait_init;
                        r_state <= ST_WAIT_SI;
                    end else begin
                        r_state <= ST_GET_SI;
                    end
                end
                ST_WAIT_SI: begin
                    if (r_wait == 4'd0) r_state <= ST_GET_SI;
                    else                r_wait  <= r_wait - 4'd1;
                end
                ST_GET_SI: begin
                    r_si      <= s_ram_q;
                    r_j       <= r_j + s_ram_q;
                    s_address <= r_j + s_ram_q;
                    r_state   <= ST_RD_SJ;
                end
                ST_RD_SJ: begin
                    if (c_use_wait) begin
                        r_wait  <= c_wait_init;
                        r_state <= ST_WAIT_SJ;
                    end else begin
                        r_state <= ST_GET_SJ;
                    end
                end
                ST_WAIT_SJ: begin
                    if (r_wait == 4'd0) r_state <= ST_GET_SJ;
                    else                r_wait  <= r_wait - 4'd1;
                end
                ST_GET_SJ: begin
                    r_sj      <= s_ram_q;
                    s_address <= r_i;
                    s_data    <= s_ram_q;
                    s_wren    <= 1'b1;
                    r_state   <= ST_WR_SI;
                end
                ST_WR_SI: begin
                    s_address <= r_j;
                    s_data    <= r_si;
                    s_wren    <= 1'b1;
                    r_state   <= ST_WR_SJ;
                end
                ST_WR_SJ: begin
                    s_address <= r_si + r_sj;
                    e_address <= r_k;
                    r_state   <= ST_RD_F;
                end
                ST_RD_F: begin
                    if (c_use_wait) begin
                        r_wait  <= c_wait_init;
                        r_state <= ST_WAIT_F;
                    end else begin
                        r_state <= ST_GET_F;
                    end
                end
                ST_WAIT_F: begin
                    if (r_wait == 4'd0) r_state <= ST_GET_F;
                    else                r_wait  <= r_wait - 4'd1;
                end
                ST_GET_F: begin
                    d_address <= r_k;
                    d_data    <= w_f8 ^ e_rom_q;
                    d_wren    <= 1'b1;
                    r_state   <= ST_WR_D;
                end
                ST_WR_D: begin
                    if (w_bad) begin
                        valid     <= 1'b0;
                        fail_addr <= r_k;
                        finish    <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (w_last) begin
                        valid   <= 1'b1;
                        finish  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_k       <= r_k + E_AW'(1);
                        r_i       <= r_i + S_AW'(1);
                        s_address <= r_i + S_AW'(1);
                        r_state   <= ST_RD_SI;
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        finish  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rc4_prga_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc4_prga_engine
// Brief    : Scoreboard bench for rc4_prga_engine over three parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rc4_prga_engine;

    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NI-1:0] start;
    logic [NI-1:0] mem_init;
    logic [NI-1:0] e_ld;
    logic [8:0]    msg_len;
    logic [7:0]    e_ld_addr;
    logic [7:0]    e_ld_data;

    wire [NI-1:0] s_wren_v, d_wren_v, valid_v, finish_v;
    wire [7:0]    s_addr_v [NI];
    wire [7:0]    s_data_v [NI];
    wire [7:0]    e_addr_v [NI];
    wire [7:0]    d_addr_v [NI];
    wire [7:0]    d_data_v [NI];
    wire [7:0]    fail_v   [NI];

    always #5 clk = ~clk;

    // Instance 0: defaults; 1: RD_LAT=2; 2: E_AW=8 without plaintext check.
    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_inst
            localparam int EAW = (g == 2) ? 8 : 5;
            localparam int RL  = (g == 1) ? 2 : 1;
            localparam int CM  = (g == 2) ? 0 : 1;

            logic [7:0]     s_mem [256];
            logic [7:0]     e_mem [256];
            logic [7:0]     d_mem [256];
            logic [7:0]     s_address, s_data, s_ram_q, s_q1, s_q2;
            logic [7:0]     e_rom_q, e_q1, e_q2, d_data;
            logic [EAW-1:0] e_address, d_address, fail_addr;
            logic           s_wren, d_wren, valid, finish;

            rc4_prga_engine #(
                .S_AW(8), .E_AW(EAW), .RD_LAT(RL), .CHECK_MODE(CM)
            ) dut (
                .clk(clk), .reset_n(reset_n), .start(start[g]),
                .msg_len(msg_len[EAW:0]),
                .s_address(s_address), .s_data(s_data), .s_wren(s_wren),
                .s_ram_q(s_ram_q), .e_address(e_address), .e_rom_q(e_rom_q),
                .d_address(d_address), .d_data(d_data), .d_wren(d_wren),
                .valid(valid), .fail_addr(fail_addr), .finish(finish)
            );

            always @(posedge clk) begin
                if (mem_init[g]) begin
                    for (int x = 0; x < 256; x++) begin
                        s_mem[x] <= 8'(x);
                        d_mem[x] <= 8'h00;
                    end
                end else begin
                    if (s_wren) s_mem[s_address] <= s_data;
                    if (d_wren) d_mem[8'(d_address)] <= d_data;
                end
                if (e_ld[g]) e_mem[e_ld_addr] <= e_ld_data;
                s_q1 <= s_mem[s_address];
                s_q2 <= s_q1;
                e_q1 <= e_mem[8'(e_address)];
                e_q2 <= e_q1;
            end

            assign s_ram_q     = (RL == 2) ? s_q2 : s_q1;
            assign e_rom_q     = (RL == 2) ? e_q2 : e_q1;
            assign s_wren_v[g] = s_wren;
            assign d_wren_v[g] = d_wren;
            assign valid_v[g]  = valid;
            assign finish_v[g] = finish;
            assign s_addr_v[g] = s_address;
            assign s_data_v[g] = s_data;
            assign e_addr_v[g] = 8'(e_address);
            assign d_addr_v[g] = 8'(d_address);
            assign d_data_v[g] = d_data;
            assign fail_v[g]   = 8'(fail_addr);
        end
    endgenerate

    int n_checks = 0;
    int n_errors = 0;
    int dcnt [NI];
    int scnt [NI];

    logic [17:0] exp_q [$];
    logic [7:0]  ebuf  [256];
    logic [7:0]  ks    [256];
    logic [7:0]  sm    [256];
    logic        exp_valid;
    logic [7:0]  exp_fail;
    int          exp_nd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic ok_byte(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    function automatic logic [63:0] outs(input int gi);
        return 64'({s_addr_v[gi], s_data_v[gi], e_addr_v[gi], d_addr_v[gi], d_data_v[gi],
                    fail_v[gi], s_wren_v[gi], d_wren_v[gi], valid_v[gi], finish_v[gi]});
    endfunction

    // Reference PRGA starting from identity S; pushes expected D writes.
    task automatic model(input int gi, input int len, input bit chk, input bit push);
        logic [7:0] i, j, si, sj, t, db;
        for (int x = 0; x < 256; x++) sm[x] = 8'(x);
        i = 8'd0; j = 8'd0;
        exp_valid = 1'b1; exp_fail = 8'd0; exp_nd = 0;
        for (int k = 0; k < len; k++) begin
            i = i + 8'd1;
            si = sm[i];
            j = j + si;
            sj = sm[j];
            sm[i] = sj;
            sm[j] = si;
            t = si + sj;
            ks[k] = sm[t];
            db = sm[t] ^ ebuf[k];
            if (push) exp_q.push_back({2'(gi), 8'(k), db});
            exp_nd++;
            if (chk && !ok_byte(db)) begin
                exp_valid = 1'b0;
                exp_fail  = 8'(k);
                break;
            end
        end
    endtask

    task automatic prep(input int gi, input int len);
        mem_init[gi] = 1'b1;
        @(posedge clk); #1;
        mem_init[gi] = 1'b0;
        for (int k = 0; k < len; k++) begin
            e_ld_addr = 8'(k);
            e_ld_data = ebuf[k];
            e_ld      = NI'(1 << gi);
            @(posedge clk); #1;
        end
        e_ld = '0;
    endtask

    task automatic s_diff(input int gi, output int nd);
        logic [7:0] v;
        nd = 0;
        for (int x = 0; x < 256; x++) begin
            case (gi)
                0:       v = g_inst[0].s_mem[x];
                1:       v = g_inst[1].s_mem[x];
                default: v = g_inst[2].s_mem[x];
            endcase
            if (v !== sm[x]) nd++;
        end
    endtask

    task automatic run_job(input int gi, input int len, input int exp_cyc, input string tag);
        int n, d0, s0;
        d0 = dcnt[gi];
        s0 = scnt[gi];
        msg_len   = 9'(len);
        start[gi] = 1'b1;
        @(posedge clk); #1;
        msg_len = 9'd1;
        n = 0;
        while (!finish_v[gi] && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
        check_eq({tag, "_valid"}, 64'(valid_v[gi]), 64'(exp_valid));
        check_eq({tag, "_fail_addr"}, 64'(fail_v[gi]), 64'(exp_fail));
        repeat (2) @(posedge clk);
        #1;
        check_eq({tag, "_finish_hold"}, 64'(finish_v[gi]), 64'(1));
        start[gi] = 1'b0;
        @(posedge clk); #1;
        check_eq({tag, "_finish_drop"}, 64'(finish_v[gi]), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check_eq({tag, "_d_writes"}, 64'(dcnt[gi] - d0), 64'(exp_nd));
        check_eq({tag, "_s_writes"}, 64'(scnt[gi] - s0), 64'(2 * exp_nd));
        check_eq({tag, "_queue_left"}, 64'(exp_q.size()), 64'(0));
    endtask

    always @(negedge clk) begin
        for (int g2 = 0; g2 < NI; g2++) begin
            scnt[g2] += int'(s_wren_v[g2]);
            if (d_wren_v[g2]) begin
                dcnt[g2]++;
                if (exp_q.size() == 0)
                    check_eq("d_unexpected", 64'({2'(g2), d_addr_v[g2], d_data_v[g2]}), 64'(0));
                else
                    check_eq("d_write", 64'({2'(g2), d_addr_v[g2], d_data_v[g2]}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nd, n, s0, d0;
        logic [47:0] ptv;

        reset_n = 1'b0; start = '0; mem_init = '0; e_ld = '0;
        msg_len = '0; e_ld_addr = '0; e_ld_data = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int gi = 0; gi < NI; gi++) check_eq("reset_outputs", outs(gi), 64'(0));
        reset_n = 1'b1;

        // Identity S, E = {63,66}
        ebuf[0] = 8'h63; ebuf[1] = 8'h66;
        model(0, 2, 1'b1, 1'b1);
        prep(0, 2);
        run_job(0, 2, 18, "s1");
        check_eq("s1_d0", 64'(g_inst[0].d_mem[0]), 64'h61);
        check_eq("s1_d1", 64'(g_inst[0].d_mem[1]), 64'h63);
        check_eq("s1_s2", 64'(g_inst[0].s_mem[2]), 64'h03);
        check_eq("s1_s3", 64'(g_inst[0].s_mem[3]), 64'h02);
        s_diff(0, nd);
        check_eq("s1_s_table", 64'(nd), 64'(0));

        // First byte invalid -> early abort
        ebuf[0] = 8'h02; ebuf[1] = 8'h66;
        model(0, 2, 1'b1, 1'b1);
        prep(0, 2);
        run_job(0, 2, 9, "s2");
        check_eq("s2_d0", 64'(g_inst[0].d_mem[0]), 64'h00);

        // Zero length
        model(0, 0, 1'b1, 1'b1);
        run_job(0, 0, 0, "s3");

        // Full 256-byte message, i wraps on the last byte
        for (int k = 0; k < 256; k++) ebuf[k] = 8'($urandom_range(0, 255));
        model(2, 256, 1'b0, 1'b1);
        prep(2, 256);
        run_job(2, 256, 2304, "s4");
        s_diff(2, nd);
        check_eq("s4_s_table", 64'(nd), 64'(0));

        // Asynchronous reset while WR_SI is active
        ebuf[0] = 8'h63; ebuf[1] = 8'h66;
        prep(0, 2);
        s0 = scnt[0];
        d0 = dcnt[0];
        msg_len  = 9'd2;
        start[0] = 1'b1;
        n = 0;
        @(posedge clk); #1;
        while (!s_wren_v[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("s5_reached_wr_si", 64'(s_wren_v[0]), 64'(1));
        reset_n = 1'b0;
        #1;
        check_eq("s5_async_outputs", outs(0), 64'(0));
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("s5_no_s_write", 64'(scnt[0] - s0), 64'(0));
        check_eq("s5_no_d_write", 64'(dcnt[0] - d0), 64'(0));
        check_eq("s5_s1_intact", 64'(g_inst[0].s_mem[1]), 64'h01);
        reset_n = 1'b1;
        model(0, 2, 1'b1, 1'b1);
        prep(0, 2);
        run_job(0, 2, 18, "s5r");
        check_eq("s5r_d0", 64'(g_inst[0].d_mem[0]), 64'h61);
        check_eq("s5r_d1", 64'(g_inst[0].d_mem[1]), 64'h63);

        // RD_LAT = 2 rerun of the first scenario
        model(1, 2, 1'b1, 1'b1);
        prep(1, 2);
        run_job(1, 2, 24, "s6");
        check_eq("s6_d0", 64'(g_inst[1].d_mem[0]), 64'h61);
        check_eq("s6_d1", 64'(g_inst[1].d_mem[1]), 64'h63);
        s_diff(1, nd);
        check_eq("s6_s_table", 64'(nd), 64'(0));

        // Plaintext "hel!o ": abort at byte 3
        ptv = 48'h68656C216F20;
        model(0, 6, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) ebuf[k] = ks[k] ^ ptv[47 - 8 * k -: 8];
        model(0, 6, 1'b1, 1'b1);
        prep(0, 6);
        run_job(0, 6, 36, "s7");
        check_eq("s7_d2", 64'(g_inst[0].d_mem[2]), 64'h6C);
        check_eq("s7_d4_untouched", 64'(g_inst[0].d_mem[4]), 64'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
